// File: rtl/cr_su_upd_gen.sv
// Schedule-update generator: folds per-request byte events into scheduler update words.
// Optional backpressure stall counter enabled by CR_SU_UPD_GEN_STALL_CNT_EN.
module cr_su_upd_gen #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] UPD_THRESH = 32'h0001_0000,
  parameter int          IDLE_TMO   = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        evt_vld,
  output logic        evt_rdy,
  input  logic [31:0] evt_handle,
  input  logic [23:0] evt_bytes_in,
  input  logic [23:0] evt_bytes_out,
  input  logic        evt_last,
  output logic        su_valid,
  input  logic        su_ready,
  output logic [31:0] su_handle,
  output logic [31:0] su_bytes_in,
  output logic [31:0] su_bytes_out,
  output logic        su_last,
  output logic [15:0] stall_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] handle;
    logic [31:0] bin;
    logic [31:0] bout;
    logic        last;
  } upd_t;

  typedef enum logic {IDLE, ACCUM} state_t;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [23:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {9'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  state_t      state, state_d;
  upd_t        acc, acc_d;
  logic [15:0] timer;
  upd_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic accept, full, pop, tmo_hit, new_big;
  logic push0, push1;
  upd_t w0, w1, new_w, head;
  logic [31:0] sum_in, sum_out;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign evt_rdy = rst_n && ((CW'(FIFO_DEPTH) - count) >= CW'(2));
  assign accept  = evt_vld & evt_rdy;
  assign tmo_hit = (state == ACCUM) && (timer == 16'(IDLE_TMO - 1));
  assign new_big = ({8'b0, evt_bytes_in} >= UPD_THRESH);
  assign sum_in  = sat_add(acc.bin, evt_bytes_in);
  assign sum_out = sat_add(acc.bout, evt_bytes_out);
  assign new_w   = '{evt_handle, {8'b0, evt_bytes_in}, {8'b0, evt_bytes_out}, evt_last};

  always_comb begin
    state_d = state;
    acc_d   = acc;
    push0   = 1'b0;
    push1   = 1'b0;
    w0      = '0;
    w1      = '0;
    if (accept) begin
      if (state == ACCUM && evt_handle == acc.handle) begin
        if (evt_last || sum_in >= UPD_THRESH) begin
          push0   = 1'b1;
          w0      = '{acc.handle, sum_in, sum_out, evt_last};
          state_d = IDLE;
        end else begin
          acc_d.bin  = sum_in;
          acc_d.bout = sum_out;
        end
      end else begin
        // Old accumulation (if any) must land ahead of the new event's word.
        if (state == ACCUM) begin
          push0 = 1'b1;
          w0    = acc;
        end
        if (evt_last || new_big) begin
          state_d = IDLE;
          if (state == ACCUM) begin
            push1 = 1'b1;
            w1    = new_w;
          end else begin
            push0 = 1'b1;
            w0    = new_w;
          end
        end else begin
          state_d = ACCUM;
          acc_d   = new_w;
        end
      end
    end else if (tmo_hit && !full) begin
      push0   = 1'b1;
      w0      = acc;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      timer <= '0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      // A suppressed timeout holds the counter so the flush retries next cycle.
      if (accept || state == IDLE || (tmo_hit && !full))
        timer <= '0;
      else if (!tmo_hit)
        timer <= timer + 16'd1;
    end
  end

  assign head     = mem[rd_ptr];
  assign su_valid = (count != '0);
  assign pop      = su_valid & su_ready;

  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= w0;
    if (push1) mem[wr_ptr + AW'(1)] <= w1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  assign su_handle    = su_valid ? head.handle : '0;
  assign su_bytes_in  = su_valid ? head.bin    : '0;
  assign su_bytes_out = su_valid ? head.bout   : '0;
  assign su_last      = su_valid ? head.last   : 1'b0;

`ifdef CR_SU_UPD_GEN_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (su_valid && !su_ready && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/cr_su_upd_gen.md
# cr_su_upd_gen

Schedule-update generator: the transmit side of the scheduler-update interface that `cr_su` consumes. It sits at the tail of an engine datapath and collects per-request byte-count events. It aggregates consecutive events that share a scheduler handle and emits update words over a valid/ready handshake that honours the `su_ready` backpressure. Flushes occur on end-of-request, on a byte threshold, on a handle change, or after an idle timeout.

## Interface
- `FIFO_DEPTH`, 4: output queue entries; power of two, ≥2.
- `UPD_THRESH`, 32'h0001_0000: accumulated input-byte count that forces a partial flush.
- `IDLE_TMO`, 256: cycles without a new event before a held partial accumulation is flushed; range 1..65535.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `evt_vld`  in  1  event valid.
- `evt_rdy`  out  1  event accepted when `evt_vld & evt_rdy`.
- `evt_handle`  in  32  scheduler handle.
- `evt_bytes_in`  in  24  input bytes consumed by this event.
- `evt_bytes_out`  in  24  output bytes produced by this event.
- `evt_last`  in  1  final event of the request.
- `su_valid`  out  1  update word valid.
- `su_ready`  in  1  downstream (`cr_su`) ready.
- `su_handle`  out  32  handle of the update.
- `su_bytes_in`  out  32  aggregated input bytes.
- `su_bytes_out`  out  32  aggregated output bytes.
- `su_last`  out  1  update closes the request.
- `stall_cnt`  out  16  backpressure cycle count (see Configuration).

## Operation
- Accumulator state: `acc_handle[31:0]`, `acc_in[31:0]`, `acc_out[31:0]`.
- States:
  - IDLE: accumulator empty.
  - ACCUM: accumulator holds a partial update.
- Additions are zero-extended 24→32 and saturate at 32'hFFFF_FFFF. There is no wrap.
- `evt_rdy` = 1 when the FIFO has ≥2 free entries, else 0. It does not depend on `evt_vld`.
- Accepted event in IDLE:
  - `evt_last`=1: push {handle, in, out, last=1}; stay in IDLE.
  - Else if the zero-extended `evt_bytes_in` ≥ `UPD_THRESH`: push {…, last=0}; stay in IDLE.
  - Else: load the accumulator and go to ACCUM.
- Accepted event in ACCUM with the same handle:
  - Add the event into the accumulator.
  - If `evt_last`, or the new `acc_in` ≥ `UPD_THRESH`: push the summed word (with `last`=`evt_last`) and go to IDLE.
  - Otherwise stay in ACCUM.
- Accepted event in ACCUM with a different handle:
  - Push the old accumulator with last=0.
  - Process the new event as if in IDLE, in the same cycle.
  - This can produce two pushes in one cycle; the old word goes first.
- Idle timer:
  - 16-bit counter, cleared on every accepted event and whenever in IDLE.
  - In ACCUM, it increments each cycle with no accepted event.
  - On reaching `IDLE_TMO-1`: push the accumulator with last=0 and go to IDLE.
  - A timeout flush is suppressed in any cycle where the FIFO is full; the counter holds and the flush is retried.
- Output FIFO:
  - First-word-fall-through; `su_*` are driven from the head entry.
  - Pop on `su_valid & su_ready`.
  - Pop and push in the same cycle are allowed.
  - Order is strictly preserved.
- Reset mid-operation: the accumulator and FIFO are discarded with no flush; `su_valid` drops asynchronously.

## Timing
- Reset values:
  - `evt_rdy` 0 while `rst_n`=0; 1 from the first cycle after deassertion.
  - `su_valid` 0.
  - `su_handle`, `su_bytes_in`, `su_bytes_out`, `su_last` 0.
  - `stall_cnt` 0.
  - State IDLE; timer 0.
- Latency: when an event pushes an update in cycle N, `su_valid` is 1 in cycle N+1 if the FIFO was empty.
- A two-push cycle presents the old word at N+1 and the new word after the old one pops.
- `su_*` hold stable while `su_valid & !su_ready`. `su_valid` never retracts without a pop.
- Timeout flush: the last accepted event is in cycle N; the push occurs in cycle N+`IDLE_TMO`; `su_valid` is 1 in cycle N+`IDLE_TMO`+1 if the FIFO was empty.
- Full throughput: one event per cycle while `su_ready`=1 and FIFO occupancy ≤ `FIFO_DEPTH`-2.

## Configuration
- `CR_SU_UPD_GEN_STALL_CNT_EN`:
  - Defined: `stall_cnt` increments every cycle with `su_valid & !su_ready`. It saturates at 16'hFFFF and is cleared only by reset.
  - Undefined: `stall_cnt` is tied to 0 and no counter flops are built.

## Test plan
- Single event: handle 0x11, in 100, out 40, last=1 → one update {0x11, 100, 40, last=1} one cycle later.
- Aggregation: three events on handle 0x22 with in 10/20/30 and out 5/5/5, last only on the third → exactly one update {0x22, 60, 15, 1}.
- Handle change: event A (0x33, 8, 8, last=0), then B (0x44, 4, 4, last=1) in the next cycle → updates in order {0x33, 8, 8, 0} then {0x44, 4, 4, 1}.
- Threshold and saturation: with `UPD_THRESH`=64, events of 40 then 40 on one handle, last=0 → flush {80, last=0}. Separately, accumulating past 2^32 → `su_bytes_in`=32'hFFFF_FFFF.
- Timeout: one event on handle 0x55 with last=0 and `IDLE_TMO`=8, then no further events → update {0x55, …, last=0} 9 cycles after the event.
- Backpressure: hold `su_ready`=0 and push 3 words with `FIFO_DEPTH`=4 → `evt_rdy` drops to 0. With the macro defined, `stall_cnt` counts the held cycles. Releasing `su_ready` → all words drain in order with no loss or duplication.
